// File: rtl/data_cache_mesi_ctrl.sv
// Direct-mapped write-back L1 data cache with MESI coherence. Misses, S->M upgrades
// and snoop write-backs run over a line-wide request/ack bus; snoops win over the CPU in IDLE.
module data_cache_mesi_ctrl #(
    parameter int AddressSize = 32,
    parameter int WordSize    = 32,
    parameter int LineWords   = 8,
    parameter int NumLines    = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    input  logic                          req_we_i,
    input  logic [AddressSize-1:0]        req_addr_i,
    input  logic [WordSize-1:0]           req_wdata_i,
    input  logic [WordSize/8-1:0]         req_be_i,
    output logic                          resp_valid_o,
    output logic [WordSize-1:0]           resp_rdata_o,
    output logic                          mem_req_o,
    output logic [1:0]                    mem_cmd_o,
    output logic [AddressSize-1:0]        mem_addr_o,
    output logic [LineWords*WordSize-1:0] mem_wdata_o,
    input  logic                          mem_ack_i,
    input  logic [LineWords*WordSize-1:0] mem_rdata_i,
    input  logic                          mem_shared_i,
    input  logic                          snoop_valid_i,
    input  logic                          snoop_inv_i,
    input  logic [AddressSize-1:0]        snoop_addr_i,
    output logic                          snoop_done_o,
    output logic                          snoop_hit_o
);
    localparam int ByteLanes   = WordSize / 8;
    localparam int LineBits    = LineWords * WordSize;
    localparam int ByteOffBits = $clog2(ByteLanes);
    localparam int OffBits     = $clog2(LineWords * ByteLanes);
    localparam int IdxBits     = $clog2(NumLines);
    localparam int TagBits     = AddressSize - IdxBits - OffBits;
    localparam int WordIdxBits = $clog2(LineWords);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RESP     = 3'd1;
    localparam logic [2:0] WB       = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] UPG      = 3'd4;
    localparam logic [2:0] SNP_WB   = 3'd5;
    localparam logic [2:0] SNP_DONE = 3'd6;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    localparam logic [1:0] CMD_GETS = 2'd0;
    localparam logic [1:0] CMD_GETM = 2'd1;
    localparam logic [1:0] CMD_UPG  = 2'd2;
    localparam logic [1:0] CMD_WB   = 2'd3;

    logic [1:0]          mesi_q [NumLines];
    logic [TagBits-1:0]  tag_q  [NumLines];
    logic [LineBits-1:0] data_q [NumLines];

    logic [2:0]             fsm_q, fsm_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [WordSize-1:0]    resp_rdata_q, resp_rdata_d;
    logic                   mem_req_q, mem_req_d;
    logic [1:0]             mem_cmd_q, mem_cmd_d;
    logic [AddressSize-1:0] mem_addr_q, mem_addr_d;
    logic [LineBits-1:0]    mem_wdata_q, mem_wdata_d;
    logic                   snoop_done_q, snoop_done_d;
    logic                   snoop_hit_q, snoop_hit_d;

    logic                   mesi_we;
    logic [IdxBits-1:0]     mesi_widx;
    logic [1:0]             mesi_wval;
    logic                   line_we;
    logic [LineBits-1:0]    line_wval;

    logic [IdxBits-1:0]     req_idx, snp_idx;
    logic [TagBits-1:0]     req_tag, snp_tag;
    logic [WordIdxBits-1:0] req_word;
    logic [1:0]             req_state, snp_state;
    logic                   req_hit, snp_hit;
    logic [LineBits-1:0]    req_line;
    logic [AddressSize-1:0] req_line_addr, snp_line_addr, victim_addr;
    logic                   unused_addr_bits;

    assign req_idx       = req_addr_i[OffBits +: IdxBits];
    assign req_tag       = req_addr_i[AddressSize-1 -: TagBits];
    assign req_word      = req_addr_i[ByteOffBits +: WordIdxBits];
    assign snp_idx       = snoop_addr_i[OffBits +: IdxBits];
    assign snp_tag       = snoop_addr_i[AddressSize-1 -: TagBits];
    assign req_state     = mesi_q[req_idx];
    assign snp_state     = mesi_q[snp_idx];
    assign req_hit       = (req_state != ST_I) && (tag_q[req_idx] == req_tag);
    assign snp_hit       = (snp_state != ST_I) && (tag_q[snp_idx] == snp_tag);
    assign req_line      = data_q[req_idx];
    assign req_line_addr = {req_addr_i[AddressSize-1:OffBits], {OffBits{1'b0}}};
    assign snp_line_addr = {snoop_addr_i[AddressSize-1:OffBits], {OffBits{1'b0}}};
    assign victim_addr   = {tag_q[req_idx], req_idx, {OffBits{1'b0}}};
    assign unused_addr_bits = ^{req_addr_i[OffBits-1:0], snoop_addr_i[OffBits-1:0]};

    function automatic logic [WordSize-1:0] word_of(input logic [LineBits-1:0] line,
                                                    input logic [WordIdxBits-1:0] w);
        return line[int'(w)*WordSize +: WordSize];
    endfunction

    function automatic logic [LineBits-1:0] merge_store(input logic [LineBits-1:0] line,
                                                        input logic [WordIdxBits-1:0] w,
                                                        input logic [WordSize-1:0] wd,
                                                        input logic [ByteLanes-1:0] be);
        logic [LineBits-1:0] r;
        r = line;
        for (int b = 0; b < ByteLanes; b++) begin
            if (be[b]) r[int'(w)*WordSize + b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        fsm_d        = fsm_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        snoop_done_d = 1'b0;
        snoop_hit_d  = 1'b0;
        mesi_we      = 1'b0;
        mesi_widx    = req_idx;
        mesi_wval    = ST_I;
        line_we      = 1'b0;
        line_wval    = req_line;

        case (fsm_q)
            IDLE: begin
                if (snoop_valid_i) begin
                    if (snp_hit && snp_state == ST_M) begin
                        fsm_d = SNP_WB;
                    end else begin
                        mesi_we      = snp_hit;
                        mesi_widx    = snp_idx;
                        mesi_wval    = snoop_inv_i ? ST_I : ST_S;
                        snoop_done_d = 1'b1;
                        snoop_hit_d  = snp_hit;
                        fsm_d        = SNP_DONE;
                    end
                end else if (req_valid_i) begin
                    if (req_hit && !req_we_i) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = word_of(req_line, req_word);
                        fsm_d        = RESP;
                    end else if (req_hit && req_state != ST_S) begin
                        line_we      = 1'b1;
                        line_wval    = merge_store(req_line, req_word, req_wdata_i, req_be_i);
                        mesi_we      = 1'b1;
                        mesi_wval    = ST_M;
                        resp_valid_d = 1'b1;
                        fsm_d        = RESP;
                    end else if (req_hit) begin
                        fsm_d = UPG;
                    end else begin
                        fsm_d = (req_state == ST_M) ? WB : FILL;
                    end
                end
            end
            RESP:     fsm_d = IDLE;
            SNP_DONE: fsm_d = IDLE;
            WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_cmd_d   = CMD_WB;
                    mem_addr_d  = victim_addr;
                    mem_wdata_d = req_line;
                end else if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    mesi_we   = 1'b1;
                    mesi_wval = ST_I;
                    fsm_d     = FILL;
                end
            end
            FILL: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_cmd_d   = req_we_i ? CMD_GETM : CMD_GETS;
                    mem_addr_d  = req_line_addr;
                    mem_wdata_d = '0;
                end else if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    line_we      = 1'b1;
                    line_wval    = req_we_i ? merge_store(mem_rdata_i, req_word, req_wdata_i, req_be_i)
                                            : mem_rdata_i;
                    mesi_we      = 1'b1;
                    mesi_wval    = req_we_i ? ST_M : (mem_shared_i ? ST_S : ST_E);
                    resp_valid_d = 1'b1;
                    resp_rdata_d = word_of(mem_rdata_i, req_word);
                    fsm_d        = RESP;
                end
            end
            UPG: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_cmd_d   = CMD_UPG;
                    mem_addr_d  = req_line_addr;
                    mem_wdata_d = '0;
                end else if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    line_we      = 1'b1;
                    line_wval    = merge_store(req_line, req_word, req_wdata_i, req_be_i);
                    mesi_we      = 1'b1;
                    mesi_wval    = ST_M;
                    resp_valid_d = 1'b1;
                    fsm_d        = RESP;
                end
            end
            SNP_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_cmd_d   = CMD_WB;
                    mem_addr_d  = snp_line_addr;
                    mem_wdata_d = data_q[snp_idx];
                end else if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    mesi_we      = 1'b1;
                    mesi_widx    = snp_idx;
                    mesi_wval    = snoop_inv_i ? ST_I : ST_S;
                    snoop_done_d = 1'b1;
                    snoop_hit_d  = 1'b1;
                    fsm_d        = SNP_DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_cmd_q    <= 2'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            snoop_done_q <= 1'b0;
            snoop_hit_q  <= 1'b0;
            for (int i = 0; i < NumLines; i++) mesi_q[i] <= ST_I;
        end else begin
            fsm_q        <= fsm_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            snoop_done_q <= snoop_done_d;
            snoop_hit_q  <= snoop_hit_d;
            if (mesi_we) mesi_q[mesi_widx] <= mesi_wval;
        end
    end

    // NOTE: tag and data arrays have no reset; an all-Invalid state array makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= line_wval;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_req_o    = mem_req_q;
    assign mem_cmd_o    = mem_cmd_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign snoop_done_o = snoop_done_q;
    assign snoop_hit_o  = snoop_hit_q;
endmodule
